// File: rtl/pipelined_addsub_pkg.sv
// Shared constants and elaboration helpers for the segmented adder/subtractor.
// Flag bit positions are also used to index the packed output flag register.
package pipelined_addsub_pkg;

  localparam int FLAG_Z   = 0;
  localparam int FLAG_N   = 1;
  localparam int FLAG_C   = 2;
  localparam int FLAG_V   = 3;
  localparam int FLAG_W   = 4;
  localparam int SEGS_MIN = 1;
  localparam int SEGS_MAX = 8;

  function automatic int seg_width(input int width, input int segs);
    return (segs > 0) ? (width / segs) : width;
  endfunction

  function automatic bit cfg_ok(input int width, input int segs);
    return (segs >= SEGS_MIN) && (segs <= SEGS_MAX) && (width > 0) && ((width % segs) == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operation/result channels of the adder/subtractor, each with valid/ready.
// The DUT uses the slave view; a producer/consumer pair uses the master view.
interface pipelined_addsub_if
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             in_bypass;
  logic [WIDTH-1:0] in_bypass_data;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;
  logic             out_neg;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_bypass, in_bypass_data, in_tag,
    output in_ready,
    output out_valid, out_result, out_carry, out_overflow, out_zero, out_neg, out_tag,
    input  out_ready
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, in_bypass, in_bypass_data, in_tag,
    input  in_ready,
    input  out_valid, out_result, out_carry, out_overflow, out_zero, out_neg, out_tag,
    output out_ready
  );

endinterface

// File: rtl/pipelined_addsub_segment.sv
// One SEG_W-bit slice of the carry-pipelined adder: sum, carry out, carry into
// the slice MSB (for signed overflow on the top slice) and a slice-zero bit.
module addsub_segment
  import pipelined_addsub_pkg::*;
#(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             carry_in,
  output logic [SEG_W-1:0] sum,
  output logic             carry_out,
  output logic             carry_msb,
  output logic             zero
);

  logic [SEG_W:0] full;

  assign full      = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, carry_in};
  assign sum       = full[SEG_W-1:0];
  assign carry_out = full[SEG_W];
  // The MSB sum bit is a^b^cin, so the carry into it falls out of an XOR.
  assign carry_msb = a[SEG_W-1] ^ b[SEG_W-1] ^ sum[SEG_W-1];
  assign zero      = ~|sum;

endmodule

// File: rtl/pipelined_addsub.sv
// Segmented carry-pipelined adder/subtractor with NZCV flags, bypass lane,
// sideband tag and a single global stall driven by the output handshake.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEGS  = 2,
  parameter int TAG_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  pipelined_addsub_if.slave  bus
);

  localparam int SEG_W = seg_width(WIDTH, SEGS);

  if (!cfg_ok(WIDTH, SEGS)) begin : g_cfg_error
    $error("pipelined_addsub: WIDTH must be a multiple of SEGS and SEGS must be 1..8");
  end

  typedef struct packed {
    logic             valid;
    logic             bypass;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] bypass_data;
    logic             carry;
    logic             carry_msb;
    logic             zero;
  } stage_t;

  stage_t            head;
  stage_t            fin;
  logic              advance;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_result_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic [FLAG_W-1:0] out_flags_q;
  logic [WIDTH-1:0]  result_d;
  logic [FLAG_W-1:0] flags_d;

  assign advance      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction is folded in here once: B is inverted and the carry-in set.
  always_comb begin
    head             = '0;
    head.valid       = bus.in_valid;
    head.bypass      = bus.in_bypass;
    head.tag         = bus.in_tag;
    head.a           = bus.in_a;
    head.b           = bus.in_sub ? ~bus.in_b : bus.in_b;
    head.bypass_data = bus.in_bypass_data;
    head.carry       = bus.in_sub;
    head.zero        = 1'b1;
  end

  for (genvar k = 0; k < SEGS; k++) begin : g_seg
    stage_t           src;
    stage_t           seg_out;
    logic [SEG_W-1:0] sum;
    logic             carry_out;
    logic             carry_msb;
    logic             zero;

    if (k == 0) begin : g_src_head
      assign src = head;
    end else begin : g_src_pipe
      assign src = g_seg[k-1].g_pipe.stg_q;
    end

    addsub_segment #(.SEG_W(SEG_W)) u_segment (
      .a         (src.a[k*SEG_W +: SEG_W]),
      .b         (src.b[k*SEG_W +: SEG_W]),
      .carry_in  (src.carry),
      .sum       (sum),
      .carry_out (carry_out),
      .carry_msb (carry_msb),
      .zero      (zero)
    );

    always_comb begin
      seg_out                         = src;
      seg_out.res[k*SEG_W +: SEG_W]   = sum;
      seg_out.carry                   = carry_out;
      seg_out.carry_msb               = carry_msb;
      seg_out.zero                    = src.zero & zero;
    end

    // The last segment feeds the output registers instead of a stage register.
    if (k < SEGS-1) begin : g_pipe
      stage_t stg_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_q <= '0;
        end else if (advance) begin
          stg_q <= seg_out;
        end
      end
    end
  end

  assign fin = g_seg[SEGS-1].seg_out;

  always_comb begin
    result_d         = fin.bypass ? fin.bypass_data : fin.res;
    flags_d          = '0;
    flags_d[FLAG_Z]  = fin.bypass ? ~|fin.bypass_data : fin.zero;
    flags_d[FLAG_N]  = result_d[WIDTH-1];
    flags_d[FLAG_C]  = !fin.bypass && fin.carry;
    flags_d[FLAG_V]  = !fin.bypass && (fin.carry ^ fin.carry_msb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
    end else if (advance) begin
      out_valid_q  <= fin.valid;
      out_result_q <= result_d;
      out_tag_q    <= fin.tag;
      out_flags_q  <= flags_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_tag      = out_tag_q;
  assign bus.out_zero     = out_flags_q[FLAG_Z];
  assign bus.out_neg      = out_flags_q[FLAG_N];
  assign bus.out_carry    = out_flags_q[FLAG_C];
  assign bus.out_overflow = out_flags_q[FLAG_V];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (SEGS=4): a queue-based reference model tracks
// every accepted op and is compared with the DUT outputs on each falling edge.
module tb_pipelined_addsub;

  localparam int WIDTH = 32;
  localparam int SEGS  = 4;
  localparam int TAG_W = 4;

  typedef struct {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic [TAG_W-1:0] tag;
    int               age;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   stim_done;
  exp_t q[$];
  exp_t pin;

  pipelined_addsub_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .SEGS(SEGS), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Plain integer arithmetic: unsigned compare for the borrow, signed 64-bit
  // range test for overflow.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub, input logic byp,
                                 input logic [WIDTH-1:0] data, input logic [TAG_W-1:0] tag);
    exp_t        e;
    logic [32:0] wide;
    longint      s;
    e.tag = tag;
    e.age = 1;
    if (byp) begin
      e.result = data;
      e.carry  = 1'b0;
      e.ovf    = 1'b0;
    end else begin
      if (sub) begin
        wide    = {1'b0, a} - {1'b0, b};
        e.carry = (a >= b);
        s       = longint'($signed(a)) - longint'($signed(b));
      end else begin
        wide    = {1'b0, a} + {1'b0, b};
        e.carry = wide[32];
        s       = longint'($signed(a)) + longint'($signed(b));
      end
      e.result = wide[31:0];
      e.ovf    = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    e.zero = (e.result == '0);
    e.neg  = e.result[WIDTH-1];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    bit exp_valid;
    bit adv;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    end else begin
      exp_valid = (q.size() > 0) && (q[0].age >= SEGS);
      checkOutput("out_valid", 64'(bus.out_valid), 64'(exp_valid));
      checkOutput("in_ready", 64'(bus.in_ready), 64'(!exp_valid || bus.out_ready));
      if (exp_valid) begin
        e = q[0];
        checkOutput("out_result", 64'(bus.out_result), 64'(e.result));
        checkOutput("out_carry", 64'(bus.out_carry), 64'(e.carry));
        checkOutput("out_overflow", 64'(bus.out_overflow), 64'(e.ovf));
        checkOutput("out_zero", 64'(bus.out_zero), 64'(e.zero));
        checkOutput("out_neg", 64'(bus.out_neg), 64'(e.neg));
        checkOutput("out_tag", 64'(bus.out_tag), 64'(e.tag));
      end
      adv = !exp_valid || bus.out_ready;
      if (adv) begin
        if (exp_valid) void'(q.pop_front());
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        if (bus.in_valid)
          q.push_back(model(bus.in_a, bus.in_b, bus.in_sub, bus.in_bypass,
                            bus.in_bypass_data, bus.in_tag));
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic sub, input logic byp,
                               input logic [WIDTH-1:0] data, input logic [TAG_W-1:0] tag);
    bit acc;
    int n;
    bus.in_valid       = 1'b1;
    bus.in_a           = a;
    bus.in_b           = b;
    bus.in_sub         = sub;
    bus.in_bypass      = byp;
    bus.in_bypass_data = data;
    bus.in_tag         = tag;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [WIDTH-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    errors    = 0;
    checks    = 0;
    stim_done = 1'b0;
    rst_n     = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_a           = '0;
    bus.in_b           = '0;
    bus.in_sub         = 1'b0;
    bus.in_bypass      = 1'b0;
    bus.in_bypass_data = '0;
    bus.in_tag         = '0;
    bus.out_ready      = 1'b1;

    $display("[TB] pinning reference model");
    pin = model(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, '0, 4'd0);
    checkOutput("pin_add_res", 64'(pin.result), 64'h0001_0000);
    checkOutput("pin_add_c", 64'(pin.carry), 64'd0);
    pin = model(32'd5, 32'd5, 1'b1, 1'b0, '0, 4'd0);
    checkOutput("pin_sub_eq_z", 64'(pin.zero), 64'd1);
    checkOutput("pin_sub_eq_c", 64'(pin.carry), 64'd1);
    pin = model(32'd3, 32'd5, 1'b1, 1'b0, '0, 4'd0);
    checkOutput("pin_sub_neg_res", 64'(pin.result), 64'hFFFF_FFFE);
    checkOutput("pin_sub_neg_c", 64'(pin.carry), 64'd0);
    pin = model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '0, 4'd0);
    checkOutput("pin_ovf_v", 64'(pin.ovf), 64'd1);
    checkOutput("pin_ovf_n", 64'(pin.neg), 64'd1);
    pin = model(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '0, 4'd0);
    checkOutput("pin_wrap_res", 64'(pin.result), 64'd0);
    checkOutput("pin_wrap_cz", 64'({pin.carry, pin.zero, pin.ovf}), 64'b110);
    pin = model(32'd0, 32'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'd9);
    checkOutput("pin_byp", 64'({pin.carry, pin.ovf, pin.neg, pin.zero}), 64'b0010);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed arithmetic and bypass");
    applyStimulus(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, '0, 4'd1);
    idle();
    drain();
    applyStimulus(32'd5, 32'd5, 1'b1, 1'b0, '0, 4'd2);
    applyStimulus(32'd3, 32'd5, 1'b1, 1'b0, '0, 4'd3);
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '0, 4'd4);
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '0, 4'd5);
    applyStimulus(32'd10, 32'd20, 1'b0, 1'b0, '0, 4'd6);
    applyStimulus(32'd1, 32'd2, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'd9);
    applyStimulus(32'd30, 32'd40, 1'b0, 1'b0, '0, 4'd7);
    idle();
    drain();

    $display("[TB] back-to-back with mid-stream stall");
    fork
      begin
        for (int i = 0; i < 8; i++)
          applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, '0, 4'(i));
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] randomized traffic with random backpressure");
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end else begin
            applyStimulus(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 5) == 0), pick_operand(), 4'($urandom));
          end
        end
        idle();
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          bus.out_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] asynchronous reset with ops in flight");
    for (int i = 0; i < 6; i++)
      applyStimulus(32'd100 + 32'(i), 32'd1, 1'b0, 1'b0, '0, 4'(i));
    idle();
    checkOutput("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async_out_result", 64'(bus.out_result), 64'd0);
    checkOutput("async_out_tag", 64'(bus.out_tag), 64'd0);
    checkOutput("async_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(32'd2, 32'd3, 1'b0, 1'b0, '0, 4'd11);
    idle();
    drain();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_reset_idle", 64'(bus.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
